// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern mode sequencer for the VGA pixel datapath.
// Arbitrates direct-select, step and auto-cycle requests; commits only at vertical sync.
module vga_pattern_sequencer #(
    parameter int unsigned NUM_MODES     = 4,
    parameter int unsigned MODE_W        = 2,
    parameter int unsigned DWELL_FRAMES  = 60,
    parameter bit          VS_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_sync,
    input  logic              disp_vld,
    input  logic              auto_en,
    input  logic              next_req,
    input  logic              sel_req,
    input  logic [MODE_W-1:0] sel_mode,
    output logic [MODE_W-1:0] mode,
    output logic              mode_vld,
    output logic              cfg_busy,
    output logic [15:0]       frame_cnt,
    output logic              err_sticky
);

    localparam int unsigned FCNT_W  = 16;
    localparam int unsigned DWELL_W = 16;
    localparam logic [MODE_W-1:0]  LAST_MODE  = MODE_W'(NUM_MODES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_e;

    state_e              state_q;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   tgt_q;
    logic                pend_q;
    logic                mode_vld_q;
    logic                cfg_busy_q;
    logic                err_q;
    logic                vs_d_q;
    logic [FCNT_W-1:0]   frame_cnt_q;
    logic [FCNT_W-1:0]   frame_cnt_d;
    logic [DWELL_W-1:0]  dwell_q;
    logic [DWELL_W-1:0]  dwell_d;

    logic                vs_act;
    logic                frame_tick;
    logic                sel_valid;
    logic                sel_bad;
    logic                auto_exp;
    logic                commit;
    logic                req_any;
    logic [MODE_W-1:0]   succ_mode;
    logic [MODE_W-1:0]   req_tgt;
    logic [MODE_W-1:0]   commit_mode;
    logic                apply_pend;

    // Sync edge detection and request resolution (sel > next > auto expiry)
    always_comb begin
        vs_act      = v_sync ^ VS_ACTIVE_LOW;
        frame_tick  = vs_act & ~vs_d_q;
        sel_valid   = sel_req && (32'(sel_mode) < NUM_MODES);
        sel_bad     = sel_req && !sel_valid;
        auto_exp    = auto_en && (state_q == IDLE) && frame_tick && (dwell_q == DWELL_LAST);
        commit      = (state_q == PEND) && frame_tick;
        succ_mode   = (mode_q == LAST_MODE) ? '0 : mode_q + MODE_W'(1);
        req_any     = sel_valid | next_req | auto_exp;
        req_tgt     = sel_valid ? sel_mode : succ_mode;
        commit_mode = sel_valid ? sel_mode : tgt_q;
        apply_pend  = pend_q | req_any;
    end

    // Frame counter and auto-cycle dwell counter
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
        dwell_d = dwell_q;
        if (!auto_en || commit) begin
            dwell_d = '0;
        end else if ((state_q == IDLE) && frame_tick) begin
            dwell_d = (dwell_q == DWELL_LAST) ? '0 : dwell_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            tgt_q       <= '0;
            pend_q      <= 1'b0;
            mode_vld_q  <= 1'b0;
            cfg_busy_q  <= 1'b0;
            err_q       <= 1'b0;
            vs_d_q      <= 1'b0;
            frame_cnt_q <= '0;
            dwell_q     <= '0;
        end else begin
            vs_d_q      <= vs_act;
            frame_cnt_q <= frame_cnt_d;
            dwell_q     <= dwell_d;
            mode_vld_q  <= 1'b0;
            if (sel_bad) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        tgt_q      <= req_tgt;
                        state_q    <= PEND;
                        cfg_busy_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (commit) begin
                        mode_q     <= commit_mode;
                        mode_vld_q <= 1'b1;
                        state_q    <= APPLY;
                    end else if (sel_valid) begin
                        tgt_q <= sel_mode;
                    end
                end
                APPLY: begin
                    // Requests seen during the sync pulse are held until it ends
                    if (req_any) begin
                        tgt_q <= req_tgt;
                    end
                    if (!vs_act) begin
                        state_q    <= apply_pend ? PEND : IDLE;
                        cfg_busy_q <= apply_pend;
                        pend_q     <= 1'b0;
                    end else if (req_any) begin
                        pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cfg_busy_q <= 1'b0;
                    pend_q     <= 1'b0;
                end
            endcase
        end
    end

    assign mode       = mode_q;
    assign mode_vld   = mode_vld_q;
    assign cfg_busy   = cfg_busy_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_sticky = err_q;

    // A frame boundary inside active video means the timing core is broken
    a_no_tick_in_active: assert property (@(posedge clk) disable iff (rst) !(frame_tick && disp_vld));

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer: frame-level reference model plus
// directed scenarios and randomized request traffic.
module tb_vga_pattern_sequencer;

    localparam int unsigned NM = 4;
    localparam int unsigned MW = 3;
    localparam int unsigned DW = 3;
    localparam int FRAME    = 32;
    localparam int SYNC_LEN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v_sync = 1'b1;
    logic          disp_vld = 1'b0;
    logic          auto_en = 1'b0;
    logic          next_req = 1'b0;
    logic          sel_req = 1'b0;
    logic [MW-1:0] sel_mode = '0;
    logic [MW-1:0] mode;
    logic          mode_vld;
    logic          cfg_busy;
    logic [15:0]   frame_cnt;
    logic          err_sticky;

    int vectors     = 0;
    int miscompares = 0;
    int pos         = 5;
    bit mon_en      = 1'b0;

    typedef struct {
        int md;
        int fc;
    } commit_t;
    commit_t exp_q[$];

    // Reference model state: what the outside world should observe
    int m_mode = 0, m_tgt = 0, m_fc = 0, m_dwell = 0;
    bit m_vld = 0, m_busy = 0, m_err = 0, m_wait = 0, m_apply = 0, m_vs_prev = 0;

    vga_pattern_sequencer #(
        .NUM_MODES    (NM),
        .MODE_W       (MW),
        .DWELL_FRAMES (DW),
        .VS_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .v_sync    (v_sync),
        .disp_vld  (disp_vld),
        .auto_en   (auto_en),
        .next_req  (next_req),
        .sel_req   (sel_req),
        .sel_mode  (sel_mode),
        .mode      (mode),
        .mode_vld  (mode_vld),
        .cfg_busy  (cfg_busy),
        .frame_cnt (frame_cnt),
        .err_sticky(err_sticky)
    );

    always #20 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: requests wait for a frame boundary, a commit holds through the sync pulse
    always @(posedge clk) begin : model
        bit vs, tick, sel_ok, expire, req, idle;
        int succ, rtgt;
        commit_t c;
        vs = (v_sync == 1'b0);
        if (rst) begin
            m_mode = 0; m_tgt = 0; m_fc = 0; m_dwell = 0;
            m_vld = 0; m_busy = 0; m_err = 0; m_wait = 0; m_apply = 0; m_vs_prev = 0;
            exp_q.delete();
        end else begin
            tick = vs && !m_vs_prev;
            m_vs_prev = vs;
            if (tick && disp_vld) begin
                miscompares++;
                $display("FAIL disp_vld_at_tick: got 1 expected 0 at %0t", $time);
            end
            sel_ok = sel_req && (int'(sel_mode) < int'(NM));
            if (sel_req && !sel_ok) m_err = 1;
            if (tick) m_fc = (m_fc + 1) % 65536;
            idle = !m_wait && !m_apply;
            expire = 0;
            if (!auto_en) m_dwell = 0;
            else if (idle && tick) begin
                if (m_dwell == int'(DW) - 1) begin
                    expire = 1;
                    m_dwell = 0;
                end else m_dwell++;
            end
            succ = (m_mode + 1) % int'(NM);
            req  = sel_ok || next_req || expire;
            rtgt = sel_ok ? int'(sel_mode) : succ;
            m_vld = 0;
            if (m_apply) begin
                if (req) begin
                    m_wait = 1;
                    m_tgt = rtgt;
                end
                if (!vs) m_apply = 0;
            end else if (m_wait) begin
                if (sel_ok) m_tgt = int'(sel_mode);
                if (tick) begin
                    m_mode = m_tgt;
                    m_vld = 1;
                    c.md = m_mode;
                    c.fc = m_fc;
                    exp_q.push_back(c);
                    m_wait = 0;
                    m_apply = 1;
                    m_dwell = 0;
                end
            end else if (req) begin
                m_wait = 1;
                m_tgt = rtgt;
            end
            m_busy = m_wait || m_apply;
        end
    end

    // Monitor: per-cycle output check plus commit scoreboard
    always @(negedge clk) begin : monitor
        commit_t c;
        if (mon_en) begin
            chk("mode", 32'(mode), 32'(m_mode));
            chk("mode_vld", 32'(mode_vld), 32'(m_vld));
            chk("cfg_busy", 32'(cfg_busy), 32'(m_busy));
            chk("err_sticky", 32'(err_sticky), 32'(m_err));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
            if (mode_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL commit_unexpected: got mode %0d expected no commit at %0t", mode, $time);
                end else begin
                    c = exp_q.pop_front();
                    chk("commit_mode", 32'(mode), 32'(c.md));
                    chk("commit_frame_cnt", 32'(frame_cnt), 32'(c.fc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pos      = (pos + 1) % FRAME;
        v_sync   = (pos < SYNC_LEN) ? 1'b0 : 1'b1;
        disp_vld = (pos >= 8 && pos < 28);
        next_req = 1'b0;
        sel_req  = 1'b0;
    endtask

    task automatic to_pos(input int p);
        do step(); while (pos != p);
    endtask

    task automatic select(input int m);
        sel_req  = 1'b1;
        sel_mode = MW'(m);
    endtask

    initial begin
        // Reset and reset values
        rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_mode", 32'(mode), 0);
        chk("rst_busy", 32'(cfg_busy), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);

        // Reset while a selection is pending discards it
        to_pos(10); select(3); step(); step();
        rst = 1'b1; step(); step(); rst = 1'b0; step();
        chk("midpend_rst_mode", 32'(mode), 0);
        chk("midpend_rst_busy", 32'(cfg_busy), 0);
        to_pos(1);
        chk("midpend_rst_no_vld", 32'(mode_vld), 0);
        chk("midpend_rst_mode2", 32'(mode), 0);

        // Direct select mid-frame
        to_pos(10); select(2); step();
        chk("sel_busy", 32'(cfg_busy), 1);
        to_pos(1);
        chk("sel_mode", 32'(mode), 2);
        chk("sel_vld", 32'(mode_vld), 1);
        step();
        chk("sel_vld_one_cycle", 32'(mode_vld), 0);

        // Priority: select beats step; step wraps from last mode
        to_pos(10); select(3); to_pos(1);
        chk("prio_setup", 32'(mode), 3);
        to_pos(10); select(1); next_req = 1'b1; to_pos(1);
        chk("prio_sel_wins", 32'(mode), 1);
        to_pos(10); select(3); to_pos(1);
        to_pos(10); next_req = 1'b1; to_pos(1);
        chk("wrap_to_zero", 32'(mode), 0);

        // Request on the frame_tick cycle waits a whole frame
        to_pos(0); next_req = 1'b1; step();
        chk("coinc_no_commit", 32'(mode), 0);
        chk("coinc_no_vld", 32'(mode_vld), 0);
        chk("coinc_busy", 32'(cfg_busy), 1);
        to_pos(1);
        chk("coinc_commit", 32'(mode), 1);
        chk("coinc_vld", 32'(mode_vld), 1);

        // Out-of-range select is ignored and latches the error
        to_pos(10); select(5); step();
        chk("bad_sel_err", 32'(err_sticky), 1);
        chk("bad_sel_mode", 32'(mode), 1);
        chk("bad_sel_busy", 32'(cfg_busy), 0);

        // Step request during the sync pulse after a commit
        to_pos(10); select(2); to_pos(1);
        next_req = 1'b1; step();
        chk("apply_busy", 32'(cfg_busy), 1);
        chk("apply_mode", 32'(mode), 2);
        to_pos(6);
        chk("apply_to_pend", 32'(cfg_busy), 1);
        to_pos(1);
        chk("apply_latch_commit", 32'(mode), 3);
        chk("apply_latch_vld", 32'(mode_vld), 1);

        // Auto-cycle with a 3-frame dwell: commit every 4th tick
        to_pos(10); select(0); to_pos(1);
        chk("auto_start", 32'(mode), 0);
        to_pos(10); auto_en = 1'b1;
        for (int f = 1; f <= 16; f++) begin
            to_pos(1);
            chk("auto_mode", 32'(mode), 32'((f / 4) % 4));
            chk("auto_vld", 32'(mode_vld), (f % 4 == 0) ? 1 : 0);
        end
        to_pos(10); auto_en = 1'b0;
        for (int f = 0; f < 6; f++) begin
            to_pos(1);
            chk("auto_off_hold", 32'(mode), 0);
        end

        // Randomized request traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom % 30 == 0) select(int'($urandom % 8));
            if ($urandom % 30 == 0) next_req = 1'b1;
            if ($urandom % 400 == 0) auto_en = ~auto_en;
            rst = ($urandom % 1000 == 0);
        end
        rst = 1'b0;
        auto_en = 1'b0;
        for (int f = 0; f < 3; f++) to_pos(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
